// File: rtl/bist_pkg.sv
// Shared BIST definitions: controller state encoding, default LFSR taps,
// default seed and signature width.
package bist_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    RUN,
    SETTLE,
    COMPARE,
    DONE
  } bist_state_e;

  localparam int DEF_SIG_WIDTH = 4;
  localparam int DEF_PAT_WIDTH = 4;
  localparam logic [DEF_PAT_WIDTH-1:0] DEF_SEED = 4'b0001;

  // Feedback taps for x^4+x^3+1: new LSB = q[3] ^ q[2]
  localparam int LFSR_TAP_A = 3;
  localparam int LFSR_TAP_B = 2;

endpackage

// File: rtl/bist_lfsr.sv
// Fibonacci LFSR pattern source: shifts left, feedback from two taps into the LSB.
// Synchronous load has priority over enable.
module bist_lfsr
  import bist_pkg::*;
#(
  parameter int                WIDTH      = DEF_PAT_WIDTH,
  parameter int                TAP_A      = LFSR_TAP_A,
  parameter int                TAP_B      = LFSR_TAP_B,
  parameter logic [WIDTH-1:0]  RESET_SEED = DEF_SEED
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic             enable,
  input  logic [WIDTH-1:0] seed,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] w_next;

  assign w_next = {r_q[WIDTH-2:0], r_q[TAP_A] ^ r_q[TAP_B]};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_q <= RESET_SEED;
    end else if (load) begin
      r_q <= seed;
    end else if (enable) begin
      r_q <= w_next;
    end
  end

  assign q = r_q;

endmodule

// File: rtl/bist_controller.sv
// BIST sequencer: drives LFSR patterns and MISR control for a fixed pattern
// count, then captures and grades the MISR signature. All outputs are registered.
module bist_controller
  import bist_pkg::*;
#(
  parameter int                    SIG_WIDTH  = DEF_SIG_WIDTH,
  parameter int                    PAT_WIDTH  = DEF_PAT_WIDTH,
  parameter int                    PAT_COUNT  = 15,
  parameter logic [PAT_WIDTH-1:0]  SEED       = DEF_SEED,
  parameter logic [SIG_WIDTH-1:0]  GOLDEN_SIG = '0
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 abort,
  input  logic [SIG_WIDTH-1:0] misr_q,
  output logic [PAT_WIDTH-1:0] pattern,
  output logic                 misr_en,
  output logic                 misr_clr,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic                 fail,
  output logic [SIG_WIDTH-1:0] sig_out
);

  localparam int               CNT_W    = $clog2(PAT_COUNT + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(PAT_COUNT - 1);

  bist_state_e          r_state;
  bist_state_e          w_nextState;
  logic                 r_start;
  logic [CNT_W-1:0]     r_count;
  logic                 r_misrEn;
  logic                 r_misrClr;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_pass;
  logic                 r_fail;
  logic [SIG_WIDTH-1:0] r_sig;
  logic                 w_lfsrLoad;
  logic                 w_lfsrEn;

  // Abort also reloads the seed so an aborted controller looks freshly reset
  assign w_lfsrLoad = (r_state == INIT) || abort;
  assign w_lfsrEn   = (r_state == RUN);

  bist_lfsr #(
    .WIDTH      (PAT_WIDTH),
    .TAP_A      (LFSR_TAP_A),
    .TAP_B      (LFSR_TAP_B),
    .RESET_SEED (SEED)
  ) u_lfsr (
    .clock  (clock),
    .reset  (reset),
    .load   (w_lfsrLoad),
    .enable (w_lfsrEn),
    .seed   (SEED),
    .q      (pattern)
  );

  always_comb begin
    w_nextState = r_state;
    if (abort) begin
      w_nextState = IDLE;
    end else begin
      case (r_state)
        IDLE:    if (r_start) w_nextState = INIT;
        INIT:    w_nextState = RUN;
        RUN:     if (r_count == LAST_CNT) w_nextState = SETTLE;
        SETTLE:  w_nextState = COMPARE;
        COMPARE: w_nextState = DONE;
        DONE:    if (r_start) w_nextState = INIT;
        default: w_nextState = IDLE;
      endcase
    end
  end

  // Start is only captured while idle or done, so requests during a run vanish
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_start   <= 1'b0;
      r_count   <= '0;
      r_misrEn  <= 1'b0;
      r_misrClr <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_pass    <= 1'b0;
      r_fail    <= 1'b0;
      r_sig     <= '0;
    end else begin
      r_state   <= w_nextState;
      r_start   <= start && !abort && ((r_state == IDLE) || (r_state == DONE));
      r_count   <= (r_state == RUN) ? r_count + CNT_W'(1) : '0;
      r_misrClr <= (w_nextState == INIT);
      r_misrEn  <= (w_nextState == RUN);
      r_busy    <= (w_nextState inside {INIT, RUN, SETTLE, COMPARE});
      r_done    <= (w_nextState == DONE);
      if (w_nextState != DONE) begin
        r_pass <= 1'b0;
        r_fail <= 1'b0;
        r_sig  <= '0;
      end else if (r_state == COMPARE) begin
        r_sig  <= misr_q;
        r_pass <= (misr_q == GOLDEN_SIG);
        r_fail <= (misr_q != GOLDEN_SIG);
      end
    end
  end

  assign misr_en  = r_misrEn;
  assign misr_clr = r_misrClr;
  assign busy     = r_busy;
  assign done     = r_done;
  assign pass     = r_pass;
  assign fail     = r_fail;
  assign sig_out  = r_sig;

endmodule

// File: tb/tb_bist_controller.sv
// Scoreboard bench for bist_controller: a stub MISR feeds misr_q, the stimulus
// pushes expected results per run and a monitor grades each done event.
module tb_bist_controller;

  localparam int         PC     = 4;
  localparam logic [3:0] SEED_V = 4'b0001;
  localparam logic [3:0] GOLD   = 4'hA;

  typedef struct {
    logic [3:0] sig;
    logic       pass;
    int         doneCycle;
  } exp_t;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [3:0] misr_q;
  logic [3:0] pattern;
  logic       misr_en, misr_clr, busy, done, pass, fail;
  logic [3:0] sig_out;

  logic [3:0] stubQ;
  logic [3:0] runMask = 4'h0;
  logic [3:0] expPat [PC];
  logic [3:0] rawSig;
  exp_t       expQ[$];
  exp_t       lastExp;
  exp_t       monItem;
  int         cycle = 0;
  int         errors = 0;
  int         checks = 0;
  int         enCount = 0;
  int         clrCount = 0;
  logic       prevDone = 1'b0;

  bist_controller #(
    .SIG_WIDTH  (4),
    .PAT_WIDTH  (4),
    .PAT_COUNT  (PC),
    .SEED       (SEED_V),
    .GOLDEN_SIG (GOLD)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .abort    (abort),
    .misr_q   (misr_q),
    .pattern  (pattern),
    .misr_en  (misr_en),
    .misr_clr (misr_clr),
    .busy     (busy),
    .done     (done),
    .pass     (pass),
    .fail     (fail),
    .sig_out  (sig_out)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cycle <= cycle + 1;

  // Stub MISR; the per-run mask lets a run be steered to any final signature
  always @(posedge clock or negedge reset) begin
    if (!reset) stubQ <= 4'h0;
    else if (misr_clr) stubQ <= 4'h0;
    else if (misr_en) stubQ <= {stubQ[2:0], stubQ[3] ^ stubQ[2]} ^ pattern;
  end
  assign misr_q = stubQ ^ runMask;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h at cycle %0d", name, act, req, cycle);
    end
  endtask

  // Caller sits on a falling edge; start is seen by the DUT on the next rising edge
  task automatic applyStimulus(input logic [3:0] mask);
    exp_t item;
    runMask        = mask;
    item.sig       = rawSig ^ mask;
    item.pass      = (item.sig == GOLD);
    item.doneCycle = cycle + PC + 5;
    expQ.push_back(item);
    lastExp = item;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic waitDrain();
    int n = 0;
    while (expQ.size() != 0 && n < 200) begin
      @(negedge clock);
      n++;
    end
    checkOutput("drainInTime", 32'(expQ.size()), 0);
    expQ.delete();
  endtask

  // Monitor: grades each rising done against the oldest expectation
  always @(negedge clock) begin
    if (reset) begin
      if (done && !prevDone) begin
        checkOutput("doneHasExpectation", 32'(expQ.size() > 0), 1);
        if (expQ.size() > 0) begin
          monItem = expQ.pop_front();
          checkOutput("sigOut", 32'(sig_out), 32'(monItem.sig));
          checkOutput("pass", 32'(pass), 32'(monItem.pass));
          checkOutput("fail", 32'(fail), 32'(!monItem.pass));
          checkOutput("doneCycle", cycle, monItem.doneCycle);
          checkOutput("misrEnCycles", enCount, PC);
          checkOutput("misrClrPulses", clrCount, 1);
        end
      end
      if (!done) checkOutput("flagsLowWithoutDone", 32'({pass, fail}), 0);
      if (!busy) clrCount = 0;
      if (misr_clr) begin
        clrCount++;
        enCount = 0;
      end
      if (misr_en) begin
        if (enCount < PC) checkOutput("pattern", 32'(pattern), 32'(expPat[enCount]));
        enCount++;
      end
    end
    prevDone = done;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cycle);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [3:0] p;
    logic [3:0] s;
    int         mode;
    logic [3:0] mask;

    // Reference: patterns are successive LFSR states from the seed; signature folds them
    p = SEED_V;
    s = 4'h0;
    for (int k = 0; k < PC; k++) begin
      expPat[k] = p;
      s = {s[2:0], s[3] ^ s[2]} ^ p;
      p = {p[2:0], p[3] ^ p[2]};
    end
    rawSig = s;

    repeat (3) @(negedge clock);
    checkOutput("rstPattern", 32'(pattern), 32'(SEED_V));
    checkOutput("rstBusy", 32'(busy), 0);
    checkOutput("rstDone", 32'(done), 0);
    checkOutput("rstPassFail", 32'({pass, fail}), 0);
    checkOutput("rstSig", 32'(sig_out), 0);
    checkOutput("rstMisrCtl", 32'({misr_en, misr_clr}), 0);
    reset = 1'b1;
    @(negedge clock);

    // Pass run, then results must hold while idle in DONE
    applyStimulus(rawSig ^ GOLD);
    waitDrain();
    repeat (20) @(negedge clock);
    checkOutput("holdDone", 32'(done), 1);
    checkOutput("holdSig", 32'(sig_out), 32'(GOLD));
    checkOutput("holdPass", 32'({pass, fail}), 32'({1'b1, 1'b0}));

    // Back-to-back: start from DONE must clear results and pulse misr_clr
    applyStimulus(rawSig ^ GOLD);
    @(negedge clock);
    checkOutput("b2bClr", 32'(misr_clr), 1);
    checkOutput("b2bBusy", 32'(busy), 1);
    checkOutput("b2bDone", 32'({done, pass, fail}), 0);
    waitDrain();

    applyStimulus(rawSig ^ 4'h5);
    waitDrain();
    checkOutput("failSig", 32'(sig_out), 32'h5);
    checkOutput("failFlags", 32'({pass, fail}), 32'({1'b0, 1'b1}));

    // Start during RUN is ignored
    applyStimulus(rawSig ^ GOLD);
    repeat (3) @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    waitDrain();

    // Abort during RUN
    applyStimulus(rawSig ^ GOLD);
    repeat (3) @(negedge clock);
    abort = 1'b1;
    @(negedge clock);
    abort = 1'b0;
    void'(expQ.pop_back());
    checkOutput("abortBusy", 32'(busy), 0);
    checkOutput("abortFlags", 32'({done, pass, fail, misr_en}), 0);
    repeat (3) @(negedge clock);
    checkOutput("abortStaysIdle", 32'({busy, misr_clr}), 0);

    // Start and abort together from DONE
    applyStimulus(rawSig ^ 4'h3);
    waitDrain();
    start = 1'b1;
    abort = 1'b1;
    @(negedge clock);
    start = 1'b0;
    abort = 1'b0;
    checkOutput("startAbortDone", 32'({done, pass, fail}), 0);
    repeat (3) @(negedge clock);
    checkOutput("startAbortIdle", 32'({busy, misr_clr}), 0);

    // Asynchronous reset mid-RUN, then a fresh run
    applyStimulus(rawSig ^ GOLD);
    repeat (3) @(negedge clock);
    reset = 1'b0;
    #1;
    void'(expQ.pop_back());
    checkOutput("midRstBusy", 32'(busy), 0);
    checkOutput("midRstDone", 32'(done), 0);
    checkOutput("midRstPattern", 32'(pattern), 32'(SEED_V));
    checkOutput("midRstMisrEn", 32'(misr_en), 0);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    applyStimulus(rawSig ^ GOLD);
    waitDrain();

    // Randomised runs: plain, with ignored start, or aborted
    for (int r = 0; r < 25; r++) begin
      mode = $urandom_range(0, 2);
      mask = ($urandom_range(0, 1) == 1) ? (rawSig ^ GOLD) : 4'($urandom_range(0, 15));
      applyStimulus(mask);
      if (mode == 1) begin
        repeat ($urandom_range(1, 6)) @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        waitDrain();
      end else if (mode == 2) begin
        repeat ($urandom_range(1, 6)) @(negedge clock);
        abort = 1'b1;
        @(negedge clock);
        abort = 1'b0;
        void'(expQ.pop_back());
        checkOutput("rndAbort", 32'({busy, done}), 0);
      end else begin
        waitDrain();
      end
      repeat ($urandom_range(0, 3)) @(negedge clock);
    end

    waitDrain();
    repeat (2) @(negedge clock);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
